// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear controller.
// Each raw pushbutton goes through a two-flop synchronizer, a counter-based
// debouncer and a rising-edge detector. The one-cycle press pulses then drive
// a three-state run/pause/clear machine. Its outputs are registered so that
// the downstream digit-place chain sees glitch-free stop/clear levels.

// Per-button front end: synchronize, debounce, and emit one pulse per press.
module stopwatch_debounce #(
  parameter int DB_BITS  = 18,
  parameter int DB_LIMIT = 250000
) (
  input  logic clk_base,
  input  logic reset,
  input  logic btn,
  output logic pr
);

  // The debounced level flips once the counter has seen DB_LIMIT
  // consecutive disagreeing samples, so it is compared against DB_LIMIT-1.
  localparam logic [DB_BITS-1:0] LIMIT_M1 = DB_BITS'(DB_LIMIT - 1);

  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               db_q, db_d;
  logic               db_prev_q, db_prev_d;
  logic [DB_BITS-1:0] cnt_q, cnt_d;

  // Next-state logic for the synchronizer, debounce counter and edge detector.
  always_comb begin
    s1_d      = btn;
    s2_d      = s1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    cnt_d     = cnt_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT_M1) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DB_BITS'(1);
    end
  end

  // Front-end registers; reset drops any half-counted press and pending pulse.
  always_ff @(posedge clk_base) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q     <= cnt_d;
    end
  end

  // Only the accepted rising level produces a pulse; releases are silent.
  assign pr = db_q & ~db_prev_q;

endmodule

module stopwatch_ctrl #(
  parameter int DB_BITS  = 18,
  parameter int DB_LIMIT = 250000
) (
  input  logic       clk_base,
  input  logic       reset,
  input  logic       btn_startstop,
  input  logic       btn_clear,
  output logic       stop,
  output logic       clear,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_CLEARED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } state_t;

  logic   pr_ss;
  logic   pr_clr;
  state_t state_q, state_d;
  logic   stop_q, stop_d;
  logic   clear_q, clear_d;
  logic   running_q, running_d;

  stopwatch_debounce #(
    .DB_BITS  (DB_BITS),
    .DB_LIMIT (DB_LIMIT)
  ) u_db_ss (
    .clk_base (clk_base),
    .reset    (reset),
    .btn      (btn_startstop),
    .pr       (pr_ss)
  );

  stopwatch_debounce #(
    .DB_BITS  (DB_BITS),
    .DB_LIMIT (DB_LIMIT)
  ) u_db_clr (
    .clk_base (clk_base),
    .reset    (reset),
    .btn      (btn_clear),
    .pr       (pr_clr)
  );

  // Transition rules; clearing is only honoured while paused, and it wins
  // over a simultaneous start/stop press. Outputs are decoded from the next
  // state so the registered outputs change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEARED: if (pr_ss) state_d = ST_RUNNING;
      ST_RUNNING: if (pr_ss) state_d = ST_PAUSED;
      ST_PAUSED: begin
        if (pr_clr) begin
          state_d = ST_CLEARED;
        end else if (pr_ss) begin
          state_d = ST_RUNNING;
        end
      end
      default: state_d = ST_CLEARED;
    endcase
    stop_d    = (state_d != ST_RUNNING);
    clear_d   = (state_d == ST_CLEARED);
    running_d = (state_d == ST_RUNNING);
  end

  // State and Moore output registers.
  always_ff @(posedge clk_base) begin
    if (reset) begin
      state_q   <= ST_CLEARED;
      stop_q    <= 1'b1;
      clear_q   <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stop_q    <= stop_d;
      clear_q   <= clear_d;
      running_q <= running_d;
    end
  end

  assign stop    = stop_q;
  assign clear   = clear_q;
  assign running = running_q;
  assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios with hard timing expectations,
// then random button activity, all compared each cycle against a window-based
// reference model of the debouncers and the run/pause/clear rules.
module tb_stopwatch_ctrl;

  localparam int DB_BITS  = 3;
  localparam int DB_LIMIT = 4;

  // clock/reset block
  logic       clk_base = 1'b0;
  logic       reset = 1'b1;
  logic       btn_startstop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       stop;
  logic       clear;
  logic       running;
  logic [1:0] state;

  always #5 clk_base = ~clk_base;

  stopwatch_ctrl #(
    .DB_BITS  (DB_BITS),
    .DB_LIMIT (DB_LIMIT)
  ) dut (
    .clk_base      (clk_base),
    .reset         (reset),
    .btn_startstop (btn_startstop),
    .btn_clear     (btn_clear),
    .stop          (stop),
    .clear         (clear),
    .running       (running),
    .state         (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. State: 0 cleared, 1 running, 2 paused.
  // A button level is accepted once the last DB_LIMIT synchronized samples
  // (the raw value two edges earlier) all disagree with the accepted level.
  int                  m_state = 0;
  bit                  m_pipe[2][2];
  bit [DB_LIMIT-1:0]   m_hist[2];
  int                  m_hist_n[2];
  bit                  m_db[2];
  bit                  m_pend[2];

  task automatic model_edge(input bit ss, input bit clr, input bit rst);
    bit raw[2];
    bit s2;
    raw[0] = ss;
    raw[1] = clr;
    if (rst) begin
      m_state = 0;
      for (int b = 0; b < 2; b++) begin
        m_pipe[b][0] = 1'b0;
        m_pipe[b][1] = 1'b0;
        m_hist[b]    = '0;
        m_hist_n[b]  = 0;
        m_db[b]      = 1'b0;
        m_pend[b]    = 1'b0;
      end
    end else begin
      if (m_state == 2 && m_pend[1]) m_state = 0;
      else if (m_pend[0]) m_state = (m_state == 1) ? 2 : 1;
      for (int b = 0; b < 2; b++) begin
        s2 = m_pipe[b][1];
        m_pipe[b][1] = m_pipe[b][0];
        m_pipe[b][0] = raw[b];
        m_hist[b] = {m_hist[b][DB_LIMIT-2:0], s2};
        if (m_hist_n[b] < DB_LIMIT) m_hist_n[b]++;
        m_pend[b] = 1'b0;
        if (m_hist_n[b] == DB_LIMIT && m_hist[b] == {DB_LIMIT{~m_db[b]}}) begin
          m_db[b]   = ~m_db[b];
          m_pend[b] = m_db[b];
        end
      end
    end
  endtask

  // driver: apply inputs for one edge, then compare against the model
  task automatic step(input bit ss, input bit clr, input bit rst);
    btn_startstop = ss;
    btn_clear     = clr;
    reset         = rst;
    @(posedge clk_base);
    #1;
    model_edge(ss, clr, rst);
    check("state",   32'(state),   32'(m_state));
    check("stop",    32'(stop),    32'(m_state != 1));
    check("clear",   32'(clear),   32'(m_state == 0));
    check("running", 32'(running), 32'(m_state == 1));
  endtask

  task automatic hold(input bit ss, input bit clr, input int n);
    for (int i = 0; i < n; i++) step(ss, clr, 1'b0);
  endtask

  initial begin
    int seg_len;
    bit r_ss, r_clr;

    // reset and idle
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("idle_state", 32'(state), 32'd0);
      check("idle_outs", {29'd0, stop, clear, running}, 32'b110);
    end

    // clean start press: running exactly from edge 7
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("start_lat", 32'(state), (i >= 7) ? 32'd1 : 32'd0);
    end
    check("start_outs", {29'd0, stop, clear, running}, 32'b001);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("start_release", 32'(state), 32'd1);
    end

    // bouncing press 1,0,1,0,1 then held: one transition, to paused, at edge 11
    for (int i = 1; i <= 15; i++) begin
      step((i == 2 || i == 4) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      check("bounce", 32'(state), (i >= 11) ? 32'd2 : 32'd1);
    end
    check("bounce_outs", {30'd0, stop, clear}, 32'b10);
    hold(1'b0, 1'b0, 10);

    // clear ignored while running, honoured while paused
    hold(1'b1, 1'b0, 10); hold(1'b0, 1'b0, 10);
    check("resume", 32'(state), 32'd1);
    hold(1'b0, 1'b1, 10); hold(1'b0, 1'b0, 10);
    check("clr_running", 32'(state), 32'd1);
    hold(1'b1, 1'b0, 10); hold(1'b0, 1'b0, 10);
    check("pause", 32'(state), 32'd2);
    hold(1'b0, 1'b1, 10);
    check("clr_paused", 32'(state), 32'd0);
    check("clr_paused_out", 32'(clear), 32'd1);
    hold(1'b0, 1'b0, 10);

    // both pressed while paused: clear wins, never passes through running
    hold(1'b1, 1'b0, 10); hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 10); hold(1'b0, 1'b0, 10);
    check("both_pre", 32'(state), 32'd2);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("both", 32'(state), (i >= 7) ? 32'd0 : 32'd2);
    end
    hold(1'b0, 1'b0, 10);

    // reset mid-debounce while running with the button held
    hold(1'b1, 1'b0, 10); hold(1'b0, 1'b0, 10);
    check("rst_pre", 32'(state), 32'd1);
    hold(1'b1, 1'b0, 4);
    step(1'b1, 1'b0, 1'b1);
    check("rst_edge", 32'(state), 32'd0);
    check("rst_outs", {29'd0, stop, clear, running}, 32'b110);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("rst_held", 32'(state), (i >= 7) ? 32'd1 : 32'd0);
    end
    hold(1'b0, 1'b0, 10);

    // random button activity with occasional resets
    for (int s = 0; s < 250; s++) begin
      r_ss    = 1'($urandom_range(0, 1));
      r_clr   = 1'($urandom_range(0, 1));
      seg_len = $urandom_range(1, 10);
      if ($urandom_range(0, 39) == 0) step(r_ss, r_clr, 1'b1);
      hold(r_ss, r_clr, seg_len);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
